// File: rtl/riscv_pkg.sv
// Shared core definitions: base opcodes, canonical NOP, fetch FSM states.
// No logic; constants and types only.
// No flow control.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_RTYPE  = 7'b011_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_ITYPE  = 7'b001_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instruction} entries with flush.
// Latency: a push is visible at the head on the next cycle; head is read combinationally.
// Backpressure: caller must not push when full; clear overrides push and pop.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    input  logic                   clear,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;
    logic          full;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !clear;
    assign do_pop   = pop && !clear && !empty;
    assign head_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(do_push && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, imem req/ack, buffering, redirect flush.
// Latency: instruction valid toward decode one cycle after its imem ack.
// Backpressure: instr_ready stalls the head; requests stop while the buffer is full.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } fetch_entry_t;

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] tgt_q;
    logic [XLEN-1:0] tgt_nxt;
    logic            req_q;
    logic            req_nxt;
    logic [XLEN-1:0] redirect_aligned;

    logic            ack_vld;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    fetch_entry_t    push_ent;
    fetch_entry_t    head_ent;

    assign redirect_aligned = redirect_pc & ~(XLEN'(3));

    assign ack_vld  = req_q && imem_ack;
    assign push     = ack_vld && (state == FETCH) && !redirect;
    assign pop      = !fifo_empty && instr_ready && !redirect;
    assign push_ent = '{pc: pc_q, ins: imem_rdata};

    // Occupancy after this edge, used to decide whether another request fits.
    assign count_nxt = redirect ? '0 : (count + CW'(push) - CW'(pop));

    fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .clear    (redirect),
        .head_dat (head_ent),
        .count    (count),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        tgt_nxt   = tgt_q;
        req_nxt   = req_q;
        case (state)
            FETCH: begin
                if (redirect) begin
                    req_nxt = 1'b1;
                    if (req_q && !imem_ack) begin
                        // Memory still owes us a word; hold the old address until it arrives.
                        state_nxt = DISCARD;
                        tgt_nxt   = redirect_aligned;
                    end else begin
                        pc_nxt = redirect_aligned;
                    end
                end else begin
                    if (ack_vld) begin
                        pc_nxt = pc_q + XLEN'(4);
                    end
                    req_nxt = (req_q && !imem_ack) || (count_nxt < CW'(DEPTH));
                end
            end
            DISCARD: begin
                req_nxt = 1'b1;
                if (redirect) begin
                    tgt_nxt = redirect_aligned;
                end
                if (ack_vld) begin
                    state_nxt = FETCH;
                    pc_nxt    = redirect ? redirect_aligned : tgt_q;
                end
            end
            default: begin
                state_nxt = FETCH;
                req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc_q  <= RESET_PC;
            tgt_q <= RESET_PC;
            req_q <= 1'b0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            tgt_q <= tgt_nxt;
            req_q <= req_nxt;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? XLEN'(NOP_INSTR) : head_ent.ins;
    assign instr_pc    = fifo_empty ? '0 : head_ent.pc;

endmodule
